prefix_addsub_pipe: RTL and testbench

- Parametrised, pipelined Kogge-Stone (KPG parallel-prefix) adder/subtractor for the floating-point adder datapath (mantissa add/subtract after alignment).
- Generalises the fixed 16-bit, 5-level combinational prefix adder to any width, with configurable prefix levels per pipeline stage.
- Adds a valid/ready handshake with full backpressure, a runtime add/sub mode, and status flags.
- Throughput is one operation per cycle when not stalled.

---
 rtl/prefix_addsub_pipe.sv | 157 +++++++++++++++
 tb/tb_prefix_addsub_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_addsub_pipe.sv
// ============================================================================
// Module   : prefix_addsub_pipe
// Purpose  : Pipelined Kogge-Stone (KPG prefix) adder/subtractor with
//            valid/ready handshake, add/sub mode and carry/overflow/zero flags.
//            Optional macro PREFIX_ADDSUB_SAT_EN saturates sum on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefix_addsub_pipe #(
    parameter int WIDTH       = 16,
    parameter int LVL_PER_STG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NLVL = $clog2(WIDTH);
    localparam int NSTG = (NLVL + LVL_PER_STG - 1) / LVL_PER_STG;

    // Position 0 holds the effective carry-in, position i+1 holds bit i.
    typedef logic [WIDTH:0][1:0] kpg_vec_t;

    function automatic logic [1:0] kpg_op(input logic [1:0] hi, input logic [1:0] lo);
        return (hi == 2'b01) ? lo : hi;
    endfunction

    logic             stall;
    logic [NSTG:0]    vld_q;
    kpg_vec_t         gp_q [0:NSTG];
    kpg_vec_t         gp_d [1:NSTG];
    logic [WIDTH-1:0] p_q  [0:NSTG];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    logic [WIDTH-1:0] b_eff;
    kpg_vec_t         gp0_d;

    always_comb begin
        b_eff    = b ^ {WIDTH{sub}};
        gp0_d    = '0;
        gp0_d[0] = {2{cin ^ sub}};
        for (int i = 0; i < WIDTH; i++) begin
            gp0_d[i+1] = {a[i] & b_eff[i], a[i] | b_eff[i]};
        end
    end

    for (genvar k = 1; k <= NSTG; k++) begin : g_stg
        localparam int LO = (k - 1) * LVL_PER_STG;
        localparam int HI = (k * LVL_PER_STG < NLVL) ? k * LVL_PER_STG : NLVL;

        kpg_vec_t lvl_in;
        kpg_vec_t lvl_out;

        always_comb begin
            lvl_out = gp_q[k-1];
            lvl_in  = gp_q[k-1];
            for (int l = LO; l < HI; l++) begin
                lvl_in = lvl_out;
                for (int i = (1 << l); i <= WIDTH; i++) begin
                    lvl_out[i] = kpg_op(lvl_in[i], lvl_in[i - (1 << l)]);
                end
            end
        end

        assign gp_d[k] = lvl_out;
    end

    // Positions below WIDTH are fully resolved after NLVL levels; the MSB
    // carry-out may still need folding with the carry-in at position 0.
    logic [WIDTH-1:0] carry;
    logic [1:0]       top_kpg;
    logic [WIDTH-1:0] sum_raw;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = gp_q[NSTG][i][1];
        end
        top_kpg = kpg_op(gp_q[NSTG][WIDTH], gp_q[NSTG][0]);
        cout_d  = top_kpg[1];
        ovf_d   = carry[WIDTH-1] ^ cout_d;
        sum_raw = p_q[NSTG] ^ carry;
`ifdef PREFIX_ADDSUB_SAT_EN
        if (ovf_d) begin
            sum_d = cout_d ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_d = sum_raw;
        end
`else
        sum_d = sum_raw;
`endif
        zero_d = (sum_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            for (int k = 0; k <= NSTG; k++) begin
                gp_q[k] <= '0;
                p_q[k]  <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                gp_q[0] <= gp0_d;
                p_q[0]  <= a ^ b_eff;
            end
            for (int k = 1; k <= NSTG; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    gp_q[k] <= gp_d[k];
                    p_q[k]  <= p_q[k-1];
                end
            end
            out_valid_q <= vld_q[NSTG];
            if (vld_q[NSTG]) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_prefix_addsub_pipe.sv
// ============================================================================
// Module   : tb_prefix_addsub_pipe
// Purpose  : Self-checking bench: 16-bit directed/stall/reset cases and a
//            32-bit (2 levels per stage) random run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prefix_addsub_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv16 = 1'b0, ir16, sub16 = 1'b0, cin16 = 1'b0, ov16, or16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        cout16, ovf16, zero16;

    logic        iv32 = 1'b0, ir32, sub32 = 1'b0, cin32 = 1'b0, ov32, or32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0, sum32;
    logic        cout32, ovf32, zero32;

    prefix_addsub_pipe #(.WIDTH(16), .LVL_PER_STG(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .sub(sub16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    prefix_addsub_pipe #(.WIDTH(32), .LVL_PER_STG(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .sub(sub32), .cin(cin32),
        .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed/unsigned integer arithmetic view of the operation.
    function automatic exp_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                       input logic sub, input logic cin);
        longint unsigned ua, ub, full, mask;
        longint          sa, sb, sres, smax, smin;
        exp_t            e;
        mask = (64'd1 << w) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        if (!sub) begin
            full   = ua + ub + 64'(cin);
            sres   = sa + sb + longint'(cin);
            e.cout = full[w];
        end else begin
            full   = ua - ub - 64'(cin);
            sres   = sa - sb - longint'(cin);
            e.cout = (ua >= ub + 64'(cin));
        end
        e.sum = full & mask;
        e.ovf = (sres > smax) || (sres < smin);
`ifdef PREFIX_ADDSUB_SAT_EN
        if (e.ovf) e.sum = (sres > smax) ? 64'(smax) : (64'(smin) & mask);
`endif
        e.zero = (e.sum == 64'd0);
        return e;
    endfunction

    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, input logic tc, input logic [15:0] esum,
                         input logic ec, input logic eo, input logic ez);
        int n;
        @(negedge clk);
        iv16 = 1'b1; a16 = ta; b16 = tb_; sub16 = ts; cin16 = tc; or16 = 1'b1;
        #1 chk({tag, "_inready"}, 64'(ir16), 64'd1);
        @(negedge clk);
        iv16 = 1'b0;
        n = 1;
        while (!ov16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd6);
        chk({tag, "_sum"},  64'(sum16),  64'(esum));
        chk({tag, "_cout"}, 64'(cout16), 64'(ec));
        chk({tag, "_ovf"},  64'(ovf16),  64'(eo));
        chk({tag, "_zero"}, 64'(zero16), 64'(ez));
        @(negedge clk);
        chk({tag, "_drain"}, 64'(ov16), 64'd0);
    endtask

    exp_t        q16[$];
    exp_t        q32[$];
    exp_t        e;
    logic [15:0] opa [10];
    logic [15:0] opb [10];
    logic        ops [10];
    logic        opc [10];
    logic [19:0] held;
    int          sent, recvd, first_t, last_t, stale, cyc;
    logic        acc;

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", 64'(ov16), 64'd0);
        chk("rst_sum",       64'(sum16), 64'd0);
        chk("rst_flags",     64'({cout16, ovf16, zero16}), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 64'(ir16), 64'd1);

        // Directed arithmetic
        run16("add_basic", 16'h0056, 16'h005D, 1'b0, 1'b0, 16'h00B3, 1'b0, 1'b0, 1'b0);
        run16("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
`ifdef PREFIX_ADDSUB_SAT_EN
        run16("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
        run16("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
`endif
        run16("add_cin_zero", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run16("sub_borrow",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);

        // 10 back-to-back beats, out_ready low for cycles 8..11
        for (int i = 0; i < 10; i++) begin
            opa[i] = 16'($urandom); opb[i] = 16'($urandom);
            ops[i] = 1'($urandom_range(0, 1)); opc[i] = 1'($urandom_range(0, 1));
        end
        opa[3] = 16'h7FFF; opb[3] = 16'h7FFF; ops[3] = 1'b0;
        sent = 0; recvd = 0; first_t = -1; last_t = -1; held = '0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            or16 = !(t >= 8 && t <= 11);
            iv16 = (sent < 10);
            if (sent < 10) begin
                a16 = opa[sent]; b16 = opb[sent]; sub16 = ops[sent]; cin16 = opc[sent];
            end
            #1;
            if (t >= 8 && t <= 11) begin
                chk("stall_in_ready", 64'(ir16), 64'd0);
                if (t == 8) begin
                    chk("stall_valid", 64'(ov16), 64'd1);
                    held = {ov16, cout16, ovf16, zero16, sum16};
                end else begin
                    chk("stall_hold", 64'({ov16, cout16, ovf16, zero16, sum16}), 64'(held));
                end
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) begin
                    chk("bb_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q16.pop_front();
                    chk("bb_sum", 64'(sum16), e.sum);
                    chk("bb_flags", 64'({cout16, ovf16, zero16}), 64'({e.cout, e.ovf, e.zero}));
                end
                if (first_t < 0) first_t = t;
                last_t = t;
                recvd++;
            end
            if (iv16 && ir16) begin
                q16.push_back(ref_model(16, 64'(a16), 64'(b16), sub16, cin16));
                sent++;
            end
            if (t == 13) chk("bb_accept_rate", 64'(sent), 64'd10);
        end
        iv16 = 1'b0;
        chk("bb_recvd", 64'(recvd), 64'd10);
        chk("bb_out_span", 64'(last_t - first_t + 1), 64'd14);

        // Reset with 4 beats in flight
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'b0; cin16 = 1'b0;
        end
        @(negedge clk);
        iv16  = 1'b0;
        rst_n = 1'b0;
        #1 chk("midrst_out_valid", 64'(ov16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_in_ready", 64'(ir16), 64'd1);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov16) stale++;
        end
        chk("midrst_stale", 64'(stale), 64'd0);
        run16("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        // WIDTH=32, 2 levels per stage: random beats, random backpressure
        sent = 0; recvd = 0; cyc = 0; acc = 1'b0;
        while (recvd < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc) iv32 = 1'b0;
            acc  = 1'b0;
            or32 = ($urandom_range(0, 3) != 0);
            if (!iv32 && sent < 1000 && $urandom_range(0, 3) != 0) begin
                iv32 = 1'b1; a32 = $urandom; b32 = $urandom;
                sub32 = 1'($urandom_range(0, 1)); cin32 = 1'($urandom_range(0, 1));
            end
            #1;
            if (ov32 && or32) begin
                if (q32.size() == 0) begin
                    chk("r32_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    chk("r32_sum",  64'(sum32),  e.sum);
                    chk("r32_cout", 64'(cout32), 64'(e.cout));
                    chk("r32_ovf",  64'(ovf32),  64'(e.ovf));
                    chk("r32_zero", 64'(zero32), 64'(e.zero));
                end
                recvd++;
            end
            if (iv32 && ir32) begin
                q32.push_back(ref_model(32, 64'(a32), 64'(b32), sub32, cin32));
                sent++;
                acc = 1'b1;
            end
        end
        chk("r32_recvd", 64'(recvd), 64'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
